disp_sched: RTL

- Schedules which of NSRC 16-bit sources is shown on the 4-digit seven-segment display.
- Sits between the datapath registers (counters, status words) and the sseg driver.
- Takes raw board buttons, debounces them and turns them into one-cycle commands: next page, toggle auto-rotate, toggle hold.
- Outputs one registered 16-bit value plus the page index and mode flags; the index and flags are meant for the LEDs.

---
 rtl/disp_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/disp_sched.sv
// disp_sched: picks which of NSRC 16-bit sources is shown on the seven-segment display.
//
// Ports:
//   clk        system clock (10 MHz)
//   rst        asynchronous active-high reset
//   src_data   NSRC packed 16-bit sources, source k at [16k+15:16k]
//   btn_next   raw button, advance page
//   btn_mode   raw button, toggle MANUAL/AUTO
//   btn_hold   raw button, toggle display freeze
//   disp_val   registered value for the sseg driver
//   disp_sel   current page index
//   auto_mode  1 while in AUTO
//   hold       1 while the display is frozen
//
// Mode FSM:
//   state  | meaning
//   MANUAL | pages advance only on next presses; auto timer held at 0
//   AUTO   | pages also advance every AUTO_CYCLES cycles while not held
module disp_sched #(
    parameter int NSRC        = 4,
    parameter int SELW        = 2,
    parameter int DB_CYCLES   = 10000,
    parameter int AUTO_CYCLES = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NSRC*16-1:0] src_data,
    input  logic               btn_next,
    input  logic               btn_mode,
    input  logic               btn_hold,
    output logic [15:0]        disp_val,
    output logic [SELW-1:0]    disp_sel,
    output logic               auto_mode,
    output logic               hold
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int ATW = $clog2(AUTO_CYCLES + 1);
    localparam logic [DBW-1:0]  DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [ATW-1:0]  AT_LAST  = ATW'(AUTO_CYCLES - 1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(NSRC - 1);

    typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} mode_t;

    // Button index: 0 = next, 1 = mode, 2 = hold.
    logic [2:0]     btn_raw;
    logic [2:0]     sync1;
    logic [2:0]     sync2;
    logic [2:0]     level;
    logic [2:0]     press;
    logic [DBW-1:0] db_cnt [3];

    mode_t           state;
    mode_t           state_nx;
    logic [ATW-1:0]  tmr;
    logic [ATW-1:0]  tmr_nx;
    logic            hold_nx;
    logic [SELW-1:0] sel_nx;
    logic            auto_req;
    logic            advance;

    assign btn_raw = {btn_hold, btn_mode, btn_next};

    // Synchronize, debounce, and emit a registered one-cycle pulse on each
    // accepted 0->1 change of the debounced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A page advance is judged against the hold value before any toggle in
    // the same cycle, so a simultaneous next+hold still advances once.
    assign auto_req  = (state == AUTO) && !hold && (tmr == AT_LAST);
    assign advance   = (press[0] || auto_req) && !hold;
    assign auto_mode = (state == AUTO);

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        hold_nx  = hold ^ press[2];
        sel_nx   = disp_sel;
        if (advance) begin
            sel_nx = (disp_sel == SEL_LAST) ? '0 : disp_sel + 1'b1;
        end
        case (state)
            MANUAL: begin
                tmr_nx = '0;
                if (press[1]) begin
                    state_nx = AUTO;
                end
            end
            AUTO: begin
                if (press[1]) begin
                    state_nx = MANUAL;
                    tmr_nx   = '0;
                end else if (advance) begin
                    tmr_nx = '0;
                end else if (!hold) begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            default: begin
                state_nx = MANUAL;
                tmr_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MANUAL;
            tmr      <= '0;
            hold     <= 1'b0;
            disp_sel <= '0;
            disp_val <= '0;
        end else begin
            state    <= state_nx;
            tmr      <= tmr_nx;
            hold     <= hold_nx;
            disp_sel <= sel_nx;
            if (!hold) begin
                disp_val <= src_data[{disp_sel, 4'b0000} +: 16];
            end
        end
    end

endmodule
